// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: formats stores, aligns and extends loads over a req/ready bus,
// stalls the pipeline while an access is in flight, and flags misalignment and bus timeouts.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] data_m,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        zext_q;
  logic        store_q;
  logic [31:0] data_m_q;
  logic        bus_err_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic [3:0]  dmem_wstrb_q;

  logic        req;
  logic        mis;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] lane;
  logic [31:0] load_ext;

  always_comb begin
    req      = mem_read | mem_write;
    // funct3[1] set means word (10 and 11); 01 is half
    mis      = ((funct3[1:0] == 2'b01) & addr[0]) | (funct3[1] & (addr[1:0] != 2'b00));
    misalign = (state_q == StIdle) & req & mis;
    stall    = (state_q == StBusy) | ((state_q == StIdle) & req & ~mis);
  end

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = store_data;
    if (funct3[1]) begin
      wstrb_d = 4'b1111;
    end else if (funct3[0]) begin
      wstrb_d = 4'b0011 << addr[1:0];
      wdata_d = {2{store_data[15:0]}};
    end else begin
      wstrb_d = 4'b0001 << addr[1:0];
      wdata_d = {4{store_data[7:0]}};
    end
    if (!mem_write) wstrb_d = 4'b0000;
  end

  always_comb begin
    lane     = dmem_rdata >> {off_q, 3'b000};
    load_ext = dmem_rdata;
    if (!size_q[1]) begin
      if (size_q[0]) load_ext = {{16{~zext_q & lane[15]}}, lane[15:0]};
      else           load_ext = {{24{~zext_q & lane[7]}}, lane[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      zext_q       <= 1'b0;
      store_q      <= 1'b0;
      data_m_q     <= '0;
      bus_err_q    <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req && !mis) begin
            off_q        <= addr[1:0];
            size_q       <= funct3[1:0];
            zext_q       <= funct3[2];
            store_q      <= mem_write;
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= mem_write;
            dmem_addr_q  <= {addr[31:2], 2'b00};
            dmem_wdata_q <= wdata_d;
            dmem_wstrb_q <= wstrb_d;
            cnt_q        <= '0;
            state_q      <= StBusy;
          end
        end
        StBusy: begin
          if (dmem_ready) begin
            dmem_req_q <= 1'b0;
            if (!store_q) data_m_q <= load_ext;
            state_q <= StDone;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            dmem_req_q <= 1'b0;
            bus_err_q  <= 1'b1;
            if (!store_q) data_m_q <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_m     = data_m_q;
  assign bus_err    = bus_err_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wstrb = dmem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model sets per-cycle expectations that
// a single negedge process compares; literal checks after each access pin the model.
module tb_load_store_unit;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic        stall, misalign, bus_err, dmem_req, dmem_we;
  logic [31:0] data_m, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .stall(stall), .data_m(data_m),
    .misalign(misalign), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic chk = 1'b0;
  logic exp_stall = 0, exp_req = 0, exp_mis = 0, exp_berr = 0, exp_we = 0, exp_store = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, model_dm = '0;
  logic [3:0]  exp_wstrb = '0;
  int stall_cycles = 0, req_cycles = 0, mis_cycles = 0, berr_cycles = 0;
  logic        last_we = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    longint v;
    int unsigned off = a % 4;
    if (f3[1]) return rd;
    if (!f3[0]) begin
      v = longint'((rd >> (8 * off)) & 32'hFF);
      if (!f3[2] && v >= 128) v = v - 256;
    end else begin
      v = longint'((rd >> (8 * off)) & 32'hFFFF);
      if (!f3[2] && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1]) return (a % 4) != 0;
    if (f3[0]) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s;
    if (f3[1]) s = 15;
    else if (f3[0]) s = 3 << (a % 4);
    else s = 1 << (a % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3[1]) return sd;
    if (f3[0]) return (sd & 32'hFFFF) * 32'h0001_0001;
    return (sd & 32'hFF) * 32'h0101_0101;
  endfunction

  // Single compare process, sampling at the falling edge
  initial forever begin
    @(negedge clk);
    if (chk) begin
      cmp("stall", 32'(stall), 32'(exp_stall));
      cmp("dmem_req", 32'(dmem_req), 32'(exp_req));
      cmp("misalign", 32'(misalign), 32'(exp_mis));
      cmp("bus_err", 32'(bus_err), 32'(exp_berr));
      cmp("data_m", data_m, model_dm);
      if (exp_req) begin
        cmp("dmem_we", 32'(dmem_we), 32'(exp_we));
        cmp("dmem_addr", dmem_addr, exp_addr);
        cmp("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_wstrb));
        if (exp_store) cmp("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (stall) stall_cycles++;
      if (misalign) mis_cycles++;
      if (bus_err) berr_cycles++;
      if (dmem_req) begin
        req_cycles++;
        last_we = dmem_we; last_addr = dmem_addr; last_wdata = dmem_wdata;
        last_wstrb = dmem_wstrb;
      end
    end
  end

  task automatic clear_counts();
    stall_cycles = 0; req_cycles = 0; mis_cycles = 0; berr_cycles = 0;
  endtask

  // One access from IDLE; ready arrives in BUSY cycle 'delay' (never if delay >= TO)
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                        input int delay);
    logic mis;
    logic timed_out;
    mis = model_misaligned(f3, a);
    timed_out = (delay >= int'(TO));
    @(posedge clk); #1;
    clear_counts();
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd; dmem_ready = 1'b0;
    exp_stall = ~mis; exp_mis = mis; exp_req = 1'b0; exp_berr = 1'b0;
    if (mis) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0;
      return;
    end
    exp_we = wr; exp_store = wr; exp_addr = a & ~32'h3;
    exp_wstrb = wr ? model_strb(f3, a) : 4'b0000;
    exp_wdata = model_wdata(f3, sd);
    for (int i = 0; i < int'(TO); i++) begin
      @(posedge clk); #1;
      exp_stall = 1'b1; exp_mis = 1'b0; exp_req = 1'b1;
      dmem_ready = (i == delay);
      dmem_rdata = (i == delay) ? rdata : 32'hDEAD_BEEF;
      if (i == delay) break;
    end
    @(posedge clk); #1;  // DONE: request inputs still asserted and must be ignored
    dmem_ready = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_berr = timed_out;
    if (!wr) model_dm = timed_out ? 32'h0 : model_load(f3, a, rdata);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; exp_berr = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    access(1, 0, 3'b000, 32'h0000_0103, 0, 32'h80FF_1234, 0);  // LB
    cmp("lb_data", data_m, 32'hFFFF_FF80);
    cmp("lb_addr", last_addr, 32'h0000_0100);
    cmp("lb_stall_cycles", stall_cycles, 2);

    access(1, 0, 3'b101, 32'h0000_0102, 0, 32'hBEEF_0000, 0);  // LHU
    cmp("lhu_data", data_m, 32'h0000_BEEF);
    access(1, 0, 3'b001, 32'h0000_0102, 0, 32'hBEEF_0000, 1);  // LH
    cmp("lh_data", data_m, 32'hFFFF_BEEF);

    access(0, 1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 0, 0);  // SB
    cmp("sb_we", 32'(last_we), 1);
    cmp("sb_addr", last_addr, 32'h0000_0200);
    cmp("sb_wstrb", 32'(last_wstrb), 32'h2);
    cmp("sb_wdata", last_wdata, 32'hABAB_ABAB);
    cmp("sb_data_m_kept", data_m, 32'hFFFF_BEEF);

    access(0, 1, 3'b001, 32'h0000_0202, 32'h1234_5678, 0, 2);  // SH upper half
    cmp("sh_wstrb", 32'(last_wstrb), 32'hC);
    cmp("sh_wdata", last_wdata, 32'h5678_5678);

    access(1, 0, 3'b010, 32'h0000_0106, 0, 0, 0);  // LW misaligned
    @(negedge clk); #1;
    cmp("lw_mis_pulses", mis_cycles, 1);
    cmp("lw_mis_req", req_cycles, 0);
    cmp("lw_mis_stall", stall_cycles, 0);
    access(0, 1, 3'b001, 32'h0000_0107, 32'h55, 0, 0);  // SH misaligned
    @(negedge clk); #1;
    cmp("sh_mis_pulses", mis_cycles, 1);
    cmp("sh_mis_req", req_cycles, 0);

    access(1, 0, 3'b010, 32'h0000_0400, 0, 32'h1234_5678, 3);  // LW, ready late
    cmp("lw_late_data", data_m, 32'h1234_5678);
    cmp("lw_late_req_cycles", req_cycles, 4);
    cmp("lw_late_stall_cycles", stall_cycles, 5);

    access(1, 0, 3'b100, 32'h0000_0402, 0, 32'hFFFF_FFFF, 100);  // LBU, timeout
    cmp("to_data", data_m, 32'h0);
    cmp("to_berr_pulses", berr_cycles, 1);
    cmp("to_req_cycles", req_cycles, int'(TO));
    cmp("to_stall_cycles", stall_cycles, int'(TO) + 1);

    access(1, 0, 3'b110, 32'h0000_0500, 0, 32'hCAFE_F00D, 0);  // LWU encoding acts as word
    cmp("lwu_data", data_m, 32'hCAFE_F00D);

    // Reset asserted during the second BUSY cycle
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
    exp_stall = 1'b1; exp_we = 1'b0; exp_store = 1'b0; exp_addr = 32'h0000_0300;
    exp_wstrb = 4'b0000;
    @(posedge clk); #1;
    exp_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; exp_stall = 1'b0; exp_req = 1'b0; model_dm = 32'h0;
    @(negedge clk); #1;
    cmp("rst_req", 32'(dmem_req), 0);
    cmp("rst_data", data_m, 32'h0);

    access(1, 1, 3'b010, 32'h0000_0600, 32'h1122_3344, 32'h9999_9999, 0);  // read+write
    cmp("rw_we", 32'(last_we), 1);
    cmp("rw_wstrb", 32'(last_wstrb), 32'hF);
    cmp("rw_wdata", last_wdata, 32'h1122_3344);
    cmp("rw_data_m_kept", data_m, 32'h0);

    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage data access unit for the RISC-V core. It sits between the ALU result and the data memory bus, directly upstream of the writeback select.
- Performs byte, halfword and word loads and stores over a req/ready memory handshake.
- Aligns and sign- or zero-extends load data into data_m for writeback.
- Stalls the pipeline while an access is in flight. Flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, BUSY cycles with dmem_ready low before the access is abandoned with bus_err (1..255)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
mem_read  in  1  load in MEM stage
mem_write  in  1  store in MEM stage
funct3  in  3  access size/sign from instruction
addr  in  32  effective address (ALU result)
store_data  in  32  rs2 value
stall  out  1  holds the pipeline; combinational from state/inputs
data_m  out  32  extended load data to writeback select
misalign  out  1  one-cycle pulse, access rejected
bus_err  out  1  one-cycle pulse, access timed out
dmem_req  out  1  bus request (registered)
dmem_we  out  1  write enable (registered)
dmem_addr  out  32  word address, {addr[31:2],2'b00} (registered)
dmem_wdata  out  32  replicated store data (registered)
dmem_wstrb  out  4  byte strobes (registered)
dmem_ready  in  1  memory accepted/completed the access
dmem_rdata  in  32  read word, valid when dmem_ready high

Behaviour:
- Reset (rst_n low at an edge): state IDLE, timeout counter 0, all outputs 0. Applies in any state; an in-flight access is abandoned and dmem_req is 0 after that edge.
- States: IDLE, BUSY, DONE.
- Request present = mem_read | mem_write. If both are high, it is treated as a store and the read is ignored.
- Access size by funct3[1:0]:
  - 00 = byte.
  - 01 = half.
  - 10 and 11 = word.
  - Load extension: funct3[2]=1 gives zero-extend; otherwise sign-extend (word loads are unaffected).
- Misalignment:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
- IDLE behaviour:
  - Misaligned request: misalign=1 for that cycle only, stall=0, no bus activity, data_m unchanged, stay IDLE.
  - Aligned request: stall=1 combinationally. On the edge, latch the offset addr[1:0], size, sign and direction, drive the dmem_* registers, clear the counter and go to BUSY.
- Store formatting:
  - SB: wstrb = 4'b0001<<off, wdata = {4{store_data[7:0]}}.
  - SH: wstrb = 4'b0011<<off, wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = store_data.
  - Loads: wstrb = 0, we = 0.
- BUSY behaviour:
  - dmem_req=1 and stall=1. All dmem_* outputs are held stable until dmem_ready is sampled high.
  - On ready: drop req. For a load, select the byte/half at the latched offset from dmem_rdata, extend it and register it into data_m. Go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT: drop req, pulse bus_err, set data_m = 0 for a load, go to DONE.
- DONE behaviour:
  - Lasts exactly one cycle with stall=0, so the pipeline advances. Then go to IDLE.
  - Request inputs are ignored in DONE.
- data_m holds its last value until the next load completes; stores never modify it.
- Latency: with ready in the first BUSY cycle, stall is high for exactly 2 cycles and data_m is valid in the DONE cycle.

Test Plan:
- LB: addr 0x00000103, dmem_rdata 0x80FF1234, ready in the first BUSY cycle -> dmem_addr 0x100, stall high exactly 2 cycles, data_m 0xFFFFFF80 in DONE.
- LHU: addr 0x102, rdata 0xBEEF0000 -> data_m 0x0000BEEF. LH with the same values -> 0xFFFFBEEF.
- SB: addr 0x201, store_data 0x000000AB -> dmem_we 1, dmem_addr 0x200, wstrb 4'b0010, wdata 0xABABABAB, data_m unchanged.
- LW at addr 0x106 -> misalign high 1 cycle, dmem_req never asserted, stall 0. SH at 0x107 -> same response.
- Ready delayed 3 BUSY cycles -> dmem_req and outputs stable for 4 cycles, stall high 5 cycles. With TIMEOUT=8 and ready never high -> bus_err pulse after 8 BUSY cycles, data_m 0, then DONE and IDLE.
- rst_n low in the second BUSY cycle -> after that edge dmem_req 0, stall 0, data_m 0, state IDLE. With both mem_read and mem_write high -> a store is issued.
